// File: rtl/result_pipe_ex_mem_wb.sv
// EX/MEM and MEM/WB result pipeline: owns the data-memory access in MEM, the register-file
// write port in WB, and a saturating count of retired writebacks.
module result_pipe_ex_mem_wb #(
  parameter int          DATA_W     = 32,
  parameter logic [5:0]  NOP_OPCODE = 6'b000000,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [5:0]        ex_opcode,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [5:0]        EX_MEM_opcode,
  output logic [4:0]        EX_MEM_rd,
  output logic [DATA_W-1:0] ex_mem_result,
  output logic [5:0]        MEM_WB_opcode,
  output logic [4:0]        MEM_WB_rd,
  output logic [DATA_W-1:0] mem_wb_result,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_R     = 6'b011010;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rd;
    logic [DATA_W-1:0] result;
  } mem_wb_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{opcode: NOP_OPCODE, rd: '0, result: '0, store_data: '0};
  localparam mem_wb_t MEM_WB_BUBBLE = '{opcode: NOP_OPCODE, rd: '0, result: '0};

  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] wb_count_q, wb_count_d;

  function automatic logic is_writer(input logic [5:0] op);
    return (op == OP_LUI) || (op == OP_XORI) || (op == OP_R) || (op == OP_LOAD);
  endfunction

  // Hold wins over flush: a frozen pipe must not lose the instruction it is waiting on.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (!hold_i) begin
      if (flush_i || !ex_valid) begin
        ex_mem_d = EX_MEM_BUBBLE;
      end else begin
        ex_mem_d = '{opcode: ex_opcode, rd: ex_rd, result: ex_alu_result,
                     store_data: ex_store_data};
      end
      mem_wb_d.opcode = ex_mem_q.opcode;
      mem_wb_d.rd     = ex_mem_q.rd;
      mem_wb_d.result = (ex_mem_q.opcode == OP_LOAD) ? dmem_rdata : ex_mem_q.result;
    end
  end

  assign wb_we   = is_writer(mem_wb_q.opcode) && (mem_wb_q.rd != 5'd0) && !hold_i;
  assign dmem_we = (ex_mem_q.opcode == OP_STORE) && !hold_i;

  always_comb begin
    wb_count_d = wb_count_q;
    if (wb_we && (wb_count_q != {CNT_W{1'b1}})) begin
      wb_count_d = wb_count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q   <= EX_MEM_BUBBLE;
      mem_wb_q   <= MEM_WB_BUBBLE;
      wb_count_q <= '0;
    end else begin
      ex_mem_q   <= ex_mem_d;
      mem_wb_q   <= mem_wb_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign EX_MEM_opcode = ex_mem_q.opcode;
  assign EX_MEM_rd     = ex_mem_q.rd;
  assign ex_mem_result = ex_mem_q.result;
  assign dmem_addr     = ex_mem_q.result;
  assign dmem_wdata    = ex_mem_q.store_data;
  assign MEM_WB_opcode = mem_wb_q.opcode;
  assign MEM_WB_rd     = mem_wb_q.rd;
  assign mem_wb_result = mem_wb_q.result;
  assign wb_addr       = mem_wb_q.rd;
  assign wb_data       = mem_wb_q.result;
  assign wb_count      = wb_count_q;

endmodule
